// File: rtl/mca_pkg.sv
// Shared types and default bus widths for the MCA acquisition sequencer and histogram RAM.
package mca_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACQ   = 2'd2,
        ST_DUMP  = 2'd3
    } mca_state_t;

    localparam int unsigned MCA_ADDR_W = 10;
    localparam int unsigned MCA_DATA_W = 16;

endpackage

// File: rtl/mca_acq_ctrl_if.sv
// Readout stream from the sequencer to the host: valid/ready with last-word marker.
interface mca_acq_ctrl_if #(
    parameter int unsigned DATA_W = mca_pkg::MCA_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/mca_tick_gen.sv
// Time-base prescaler: one tick every TICK_DIV enabled cycles, synchronous restart.
module mca_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick_c
);
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    // Prescaler count: restart on clear, wrap after the last cycle of each tick period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (r_cnt == LAST_CNT) r_cnt <= '0;
            else                   r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // Tick lands on the same edge the count wraps, so the consumer advances in step
    assign o_tick_c = i_en && !i_clr && (r_cnt == LAST_CNT);

endmodule

// File: rtl/mca_acq_ctrl.sv
// MCA acquisition sequencer: bin clear, preset-limited acquisition, and bin readout stream.
module mca_acq_ctrl
    import mca_pkg::*;
#(
    parameter int unsigned ADDR_W   = MCA_ADDR_W,
    parameter int unsigned DATA_W   = MCA_DATA_W,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned TIME_W   = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic                cmd_clear,
    input  logic                cmd_dump,
    input  logic [CNT_W-1:0]    preset_cnt,
    input  logic [TIME_W-1:0]   preset_time,
    input  logic                adc_valid,
    input  logic [ADDR_W-1:0]   adc_code,
    output logic                ram_we,
    output logic                ram_clr,
    output logic [ADDR_W-1:0]   ram_waddr,
    output logic [ADDR_W-1:0]   ram_raddr,
    input  logic [DATA_W-1:0]   ram_rdata,
    mca_acq_ctrl_if.master      out_if,
    output logic                busy,
    output mca_state_t          state_o,
    output logic [CNT_W-1:0]    event_cnt,
    output logic [TIME_W-1:0]   time_cnt
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    mca_state_t          r_state;
    logic                r_busy;
    logic                r_ram_we;
    logic                r_ram_clr;
    logic [ADDR_W-1:0]   r_ram_waddr;
    logic [ADDR_W-1:0]   r_ram_raddr;
    logic [1:0]          r_rd_wait;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;
    logic [CNT_W-1:0]    r_event_cnt;
    logic [TIME_W-1:0]   r_time_cnt;

    logic                w_start;
    logic                w_tick;
    logic [CNT_W-1:0]    w_evt_inc;
    logic [TIME_W-1:0]   w_time_inc;
    logic                w_cnt_hit;
    logic                w_time_hit;
    logic                w_reached;

    // Accepted start: lowest priority of the IDLE commands
    assign w_start = (r_state == ST_IDLE) && cmd_start && !cmd_clear && !cmd_dump;

    mca_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start),
        .i_en     (r_state == ST_ACQ),
        .o_tick_c (w_tick)
    );

    // Saturating increments and preset checks; a preset hit on this edge still counts the event
    assign w_evt_inc  = (r_event_cnt == '1) ? r_event_cnt : r_event_cnt + CNT_W'(1);
    assign w_time_inc = (r_time_cnt == '1) ? r_time_cnt : r_time_cnt + TIME_W'(1);
    assign w_cnt_hit  = (preset_cnt != '0) && adc_valid && (w_evt_inc >= preset_cnt);
    assign w_time_hit = (preset_time != '0) && w_tick && (w_time_inc >= preset_time);
    assign w_reached  = ((preset_cnt != '0) && (r_event_cnt >= preset_cnt)) ||
                        ((preset_time != '0) && (r_time_cnt >= preset_time));

    // Sequencer state, RAM strobes, counters and readout register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_clr   <= 1'b0;
            r_ram_waddr <= '0;
            r_ram_raddr <= '0;
            r_rd_wait   <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_event_cnt <= '0;
            r_time_cnt  <= '0;
        end else begin
            r_ram_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_clear) begin
                        r_state     <= ST_CLEAR;
                        r_busy      <= 1'b1;
                        r_ram_clr   <= 1'b1;
                        r_ram_waddr <= '0;
                    end else if (cmd_dump) begin
                        r_state     <= ST_DUMP;
                        r_busy      <= 1'b1;
                        r_ram_raddr <= '0;
                        r_rd_wait   <= 2'd2;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (cmd_start) begin
                        r_state     <= ST_ACQ;
                        r_busy      <= 1'b1;
                        r_event_cnt <= '0;
                        r_time_cnt  <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_ram_waddr == LAST_ADDR) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_ram_clr <= 1'b0;
                    end else begin
                        r_ram_waddr <= r_ram_waddr + ADDR_W'(1);
                    end
                end
                ST_ACQ: begin
                    if (cmd_stop || w_reached) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (adc_valid) begin
                            r_ram_we    <= 1'b1;
                            r_ram_waddr <= adc_code;
                            r_event_cnt <= w_evt_inc;
                        end
                        if (w_tick) r_time_cnt <= w_time_inc;
                        if (w_cnt_hit || w_time_hit) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DUMP: begin
                    if (r_rd_wait == 2'd2) begin
                        r_rd_wait <= 2'd1;
                    end else if (r_rd_wait == 2'd1) begin
                        r_out_data  <= ram_rdata;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_ram_raddr == LAST_ADDR);
                        r_rd_wait   <= 2'd0;
                    end else if (r_out_valid && out_if.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_out_last <= 1'b0;
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_ram_raddr <= r_ram_raddr + ADDR_W'(1);
                            r_rd_wait   <= 2'd2;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_we           = r_ram_we;
    assign ram_clr          = r_ram_clr;
    assign ram_waddr        = r_ram_waddr;
    assign ram_raddr        = r_ram_raddr;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_data  = r_out_data;
    assign out_if.out_last  = r_out_last;
    assign busy             = r_busy;
    assign state_o          = r_state;
    assign event_cnt        = r_event_cnt;
    assign time_cnt         = r_time_cnt;

endmodule

// File: tb/tb_mca_acq_ctrl.sv
// Directed bench for mca_acq_ctrl with a behavioural increment-on-write histogram RAM.
module tb_mca_acq_ctrl;
    import mca_pkg::*;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned TIME_W   = 24;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned NBINS    = 1024;

    logic                clk;
    logic                rst;
    logic                cmd_start, cmd_stop, cmd_clear, cmd_dump;
    logic [CNT_W-1:0]    preset_cnt;
    logic [TIME_W-1:0]   preset_time;
    logic                adc_valid;
    logic [ADDR_W-1:0]   adc_code;
    logic                ram_we, ram_clr;
    logic [ADDR_W-1:0]   ram_waddr, ram_raddr;
    logic [DATA_W-1:0]   ram_rdata;
    logic                busy;
    mca_state_t          state_o;
    logic [CNT_W-1:0]    event_cnt;
    logic [TIME_W-1:0]   time_cnt;

    mca_acq_ctrl_if #(.DATA_W(DATA_W)) out_if ();

    mca_acq_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .TIME_W(TIME_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .cmd_dump(cmd_dump),
        .preset_cnt(preset_cnt), .preset_time(preset_time),
        .adc_valid(adc_valid), .adc_code(adc_code),
        .ram_we(ram_we), .ram_clr(ram_clr), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .out_if(out_if),
        .busy(busy), .state_o(state_o), .event_cnt(event_cnt), .time_cnt(time_cnt)
    );

    always #5 clk = ~clk;

    // Histogram RAM model: clear-write, increment-write, registered read
    logic [DATA_W-1:0] mem [NBINS];
    int n_we = 0;
    always @(posedge clk) begin
        if (ram_clr)     mem[ram_waddr] <= '0;
        else if (ram_we) mem[ram_waddr] <= mem[ram_waddr] + 16'd1;
        ram_rdata <= mem[ram_raddr];
        if (ram_we) n_we <= n_we + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       clr, dmp, sta, stp;
        mca_state_t exp_state;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [7];
    logic [DATA_W-1:0] exp_bin [NBINS];
    int codes [4];

    initial begin
        int we0, acq, idx, bad_clr, bad_data, bad_last, bad_stab, r;
        logic prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic prev_last;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, ST_CLEAR, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, ST_DUMP,  1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_ACQ,   1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, ST_CLEAR, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, ST_CLEAR, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, ST_IDLE,  1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,  1'b0};
        for (int i = 0; i < int'(NBINS); i++) exp_bin[i] = '0;
        exp_bin[5] = 16'd3; exp_bin[900] = 16'd1; exp_bin[7] = 16'd10;
        codes[0] = 5; codes[1] = 5; codes[2] = 5; codes[3] = 900;

        clk = 1'b0; rst = 1'b1;
        cmd_start = 0; cmd_stop = 0; cmd_clear = 0; cmd_dump = 0;
        preset_cnt = '0; preset_time = '0; adc_valid = 0; adc_code = '0;
        out_if.out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_state", 64'(state_o), 64'(ST_IDLE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({ram_we, ram_clr, out_if.out_valid, out_if.out_last}), 64'd0);
        check("rst_addr", 64'({ram_waddr, ram_raddr}), 64'd0);
        check("rst_cnts", 64'({event_cnt, time_cnt}), 64'd0);
        check("rst_data", 64'(out_if.out_data), 64'd0);
        rst = 1'b0;

        // IDLE command priority table
        for (int v = 0; v < 7; v++) begin
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            cmd_clear = vecs[v].clr; cmd_dump = vecs[v].dmp;
            cmd_start = vecs[v].sta; cmd_stop = vecs[v].stp;
            @(negedge clk);
            cmd_clear = 0; cmd_dump = 0; cmd_start = 0; cmd_stop = 0;
            check($sformatf("prio_state[%0d]", v), 64'(state_o), 64'(vecs[v].exp_state));
            check($sformatf("prio_busy[%0d]", v), 64'(busy), 64'(vecs[v].exp_busy));
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0;

        // Clear: 1024 ascending clear writes, busy drops on cycle 1025
        cmd_clear = 1; @(negedge clk); cmd_clear = 0;
        bad_clr = 0;
        adc_valid = 1; adc_code = 10'd3;
        for (int i = 0; i < int'(NBINS); i++) begin
            if (!(ram_clr && !ram_we && busy && ram_waddr == ADDR_W'(i))) bad_clr++;
            @(negedge clk);
        end
        adc_valid = 0;
        check("clr_seq_bad", 64'(bad_clr), 64'd0);
        check("clr_done_busy", 64'(busy), 64'd0);
        check("clr_done_clr", 64'(ram_clr), 64'd0);
        check("clr_done_state", 64'(state_o), 64'(ST_IDLE));

        // Acquisition: codes 5,5,5,900 back to back, then stop with a discarded strobe
        cmd_start = 1; @(negedge clk); cmd_start = 0;
        check("acq_state", 64'(state_o), 64'(ST_ACQ));
        check("acq_cnt0", 64'(event_cnt), 64'd0);
        we0 = n_we;
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1; adc_code = ADDR_W'(codes[i]);
            @(negedge clk);
            check($sformatf("acq_we[%0d]", i), 64'(ram_we), 64'd1);
            check($sformatf("acq_waddr[%0d]", i), 64'(ram_waddr), 64'(codes[i]));
        end
        adc_valid = 0;
        @(negedge clk);
        check("acq_we_idle", 64'(ram_we), 64'd0);
        check("acq_evt4", 64'(event_cnt), 64'd4);
        cmd_stop = 1; adc_valid = 1; adc_code = 10'd900;
        @(negedge clk);
        cmd_stop = 0; adc_valid = 0;
        check("stop_state", 64'(state_o), 64'(ST_IDLE));
        check("stop_we", 64'(n_we - we0), 64'd4);
        check("stop_evt", 64'(event_cnt), 64'd4);
        @(negedge clk);
        check("bin5", 64'(mem[5]), 64'd3);
        check("bin900", 64'(mem[900]), 64'd1);

        // Count preset of 10 with a continuous strobe
        preset_cnt = 32'd10; adc_code = 10'd7; adc_valid = 1;
        we0 = n_we;
        cmd_start = 1; @(negedge clk); cmd_start = 0;
        idx = 0;
        while (state_o == ST_ACQ && idx < 40) begin @(negedge clk); idx++; end
        check("pcnt_timeout", 64'(idx < 40), 64'd1);
        adc_valid = 0;
        repeat (2) @(negedge clk);
        check("pcnt_state", 64'(state_o), 64'(ST_IDLE));
        check("pcnt_we", 64'(n_we - we0), 64'd10);
        check("pcnt_evt", 64'(event_cnt), 64'd10);
        check("pcnt_bin7", 64'(mem[7]), 64'd10);
        preset_cnt = '0;

        // Time preset of 3 ticks with TICK_DIV=4: 12 ACQ cycles
        preset_time = 24'd3;
        cmd_start = 1; @(negedge clk); cmd_start = 0;
        acq = (state_o == ST_ACQ) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state_o == ST_ACQ) acq++;
            else break;
        end
        check("ptime_cycles", 64'(acq), 64'd12);
        check("ptime_tcnt", 64'(time_cnt), 64'd3);
        check("ptime_evt", 64'(event_cnt), 64'd0);
        @(negedge clk);
        check("ptime_hold", 64'(time_cnt), 64'd3);
        preset_time = '0;

        // Dump with random backpressure
        cmd_dump = 1; @(negedge clk); cmd_dump = 0;
        idx = 0; bad_data = 0; bad_last = 0; bad_stab = 0;
        prev_stall = 0; prev_data = '0; prev_last = 0;
        for (int cyc = 0; cyc < 20000 && idx < int'(NBINS); cyc++) begin
            if (prev_stall && !(out_if.out_valid && out_if.out_data == prev_data &&
                                out_if.out_last == prev_last)) bad_stab++;
            if (out_if.out_valid) begin
                if (out_if.out_data != exp_bin[idx]) bad_data++;
                if (out_if.out_last != (idx == int'(NBINS) - 1)) bad_last++;
            end
            r = int'($urandom_range(0, 1));
            out_if.out_ready = r[0];
            if (out_if.out_valid && r[0]) begin
                idx++; prev_stall = 0;
            end else begin
                prev_stall = out_if.out_valid;
            end
            prev_data = out_if.out_data; prev_last = out_if.out_last;
            @(negedge clk);
        end
        out_if.out_ready = 0;
        check("dump_words", 64'(idx), 64'(NBINS));
        check("dump_data_bad", 64'(bad_data), 64'd0);
        check("dump_last_bad", 64'(bad_last), 64'd0);
        check("dump_stable_bad", 64'(bad_stab), 64'd0);
        check("dump_end_state", 64'(state_o), 64'(ST_IDLE));
        check("dump_end_valid", 64'(out_if.out_valid), 64'd0);

        // Reset while bin 300 is pending in a dump; no resume afterwards
        cmd_dump = 1; @(negedge clk); cmd_dump = 0;
        out_if.out_ready = 1; idx = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (out_if.out_valid && idx == 300) break;
            if (out_if.out_valid) idx++;
            @(negedge clk);
        end
        check("mid_reached300", 64'(idx), 64'd300);
        rst = 1; #1;
        check("mid_rst_valid", 64'(out_if.out_valid), 64'd0);
        check("mid_rst_state", 64'(state_o), 64'(ST_IDLE));
        check("mid_rst_raddr", 64'(ram_raddr), 64'd0);
        @(negedge clk); rst = 0;
        @(negedge clk);
        check("mid_no_resume", 64'(state_o), 64'(ST_IDLE));
        cmd_start = 1; cmd_clear = 1; @(negedge clk); cmd_start = 0; cmd_clear = 0;
        check("sc_state", 64'(state_o), 64'(ST_CLEAR));
        check("sc_clr", 64'(ram_clr), 64'd1);
        idx = 0;
        while (busy && idx < 1100) begin @(negedge clk); idx++; end
        check("sc_clr_len", 64'(idx), 64'd1024);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
